// File: rtl/apb3_completer_bridge.sv
// APB3 completer that forwards each transfer as a single-beat back-end request.
// Adds wait states until the back-end answers; errors, misalignment, protocol violations and timeouts complete with pslverr.
module apb3_completer_bridge #(
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AddressWidth-1:0] i_paddr,
    input  logic                    i_pselx,
    input  logic                    i_penable,
    input  logic                    i_pwrite,
    input  logic [DataWidth-1:0]    i_pwdata,
    output logic                    o_pready,
    output logic [DataWidth-1:0]    o_prdata,
    output logic                    o_pslverr,
    output logic                    o_req_valid,
    output logic                    o_req_write,
    output logic [AddressWidth-1:0] o_req_addr,
    output logic [DataWidth-1:0]    o_req_wdata,
    input  logic                    i_rsp_valid,
    input  logic [DataWidth-1:0]    i_rsp_rdata,
    input  logic                    i_rsp_error
);

    localparam int LSB = (DataWidth > 8) ? $clog2(DataWidth / 8) : 0;
    localparam int CW  = $clog2(TimeoutCycles + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_err_hold, w_err_hold_nxt;
    logic [CW-1:0]           r_cnt, w_cnt_nxt;
    logic                    w_latch;
    logic                    w_setup;
    logic                    w_violation;
    logic                    w_misaligned;
    logic                    w_pready_nxt;
    logic                    w_pslverr_nxt;
    logic [DataWidth-1:0]    w_prdata_nxt;

    logic                    r_pready;
    logic [DataWidth-1:0]    r_prdata;
    logic                    r_pslverr;
    logic                    r_req_valid;
    logic                    r_req_write;
    logic [AddressWidth-1:0] r_req_addr;
    logic [DataWidth-1:0]    r_req_wdata;

    generate
        if (LSB == 0) begin : g_byte_bus
            assign w_misaligned = 1'b0;
        end else begin : g_wide_bus
            assign w_misaligned = |i_paddr[LSB-1:0];
        end
    endgenerate

    assign w_setup     = i_pselx & ~i_penable;
    assign w_violation = i_pselx & i_penable;

    // Errors raised from IDLE spend one cycle in ERR with pready low (err_hold),
    // so they complete with one wait state like a normal access phase would.
    always_comb begin
        w_state_nxt    = r_state;
        w_err_hold_nxt = 1'b0;
        w_cnt_nxt      = r_cnt;
        w_latch        = 1'b0;
        w_prdata_nxt   = '0;
        w_pslverr_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_setup) begin
                    w_latch = 1'b1;
                    if (w_misaligned) begin
                        w_state_nxt    = ERR;
                        w_err_hold_nxt = 1'b1;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end else if (w_violation) begin
                    w_state_nxt    = ERR;
                    w_err_hold_nxt = 1'b1;
                end
            end
            REQ: begin
                w_cnt_nxt   = '0;
                w_state_nxt = i_pselx ? WAIT : IDLE;
            end
            WAIT: begin
                if (!i_pselx) begin
                    w_state_nxt = IDLE;
                end else if (i_rsp_valid) begin
                    w_state_nxt   = RESP;
                    w_prdata_nxt  = r_req_write ? '0 : i_rsp_rdata;
                    w_pslverr_nxt = i_rsp_error;
                end else if (r_cnt == CW'(TimeoutCycles)) begin
                    w_state_nxt   = ERR;
                    w_pslverr_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            ERR: begin
                if (r_err_hold) begin
                    w_state_nxt   = ERR;
                    w_pslverr_nxt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_pready_nxt = (w_state_nxt == RESP) | ((w_state_nxt == ERR) & ~w_err_hold_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_err_hold  <= 1'b0;
            r_cnt       <= '0;
            r_pready    <= 1'b0;
            r_prdata    <= '0;
            r_pslverr   <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_err_hold  <= w_err_hold_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pready    <= w_pready_nxt;
            r_prdata    <= w_prdata_nxt;
            r_pslverr   <= w_pslverr_nxt;
            r_req_valid <= (w_state_nxt == REQ);
            if (w_latch) begin
                r_req_write <= i_pwrite;
                r_req_addr  <= i_paddr;
                r_req_wdata <= i_pwrite ? i_pwdata : '0;
            end
        end
    end

    assign o_pready    = r_pready;
    assign o_prdata    = r_prdata;
    assign o_pslverr   = r_pslverr;
    assign o_req_valid = r_req_valid;
    assign o_req_write = r_req_write;
    assign o_req_addr  = r_req_addr;
    assign o_req_wdata = r_req_wdata;

endmodule

// File: tb/tb_apb3_completer_bridge.sv
// Randomized bench for apb3_completer_bridge against a per-transfer outcome model.
module tb_apb3_completer_bridge;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic          pselx = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [DW-1:0] pwdata = '0;
    logic          o_pready;
    logic [DW-1:0] o_prdata;
    logic          o_pslverr;
    logic          o_req_valid;
    logic          o_req_write;
    logic [AW-1:0] o_req_addr;
    logic [DW-1:0] o_req_wdata;
    logic          rsp_valid = 1'b0;
    logic [DW-1:0] rsp_rdata = '0;
    logic          rsp_error = 1'b0;

    int total = 0;
    int bad   = 0;

    apb3_completer_bridge #(.AddressWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_paddr(paddr), .i_pselx(pselx), .i_penable(penable), .i_pwrite(pwrite), .i_pwdata(pwdata),
        .o_pready(o_pready), .o_prdata(o_prdata), .o_pslverr(o_pslverr),
        .o_req_valid(o_req_valid), .o_req_write(o_req_write), .o_req_addr(o_req_addr),
        .o_req_wdata(o_req_wdata),
        .i_rsp_valid(rsp_valid), .i_rsp_rdata(rsp_rdata), .i_rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        pselx = 1'b0; penable = 1'b0; rsp_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // mode: 0 = back-end answers n cycles after req_valid, 1 = never answers (late pulse after
    // completion), 2 = pselx dropped n cycles into WAIT (answer arrives afterwards), 3 = penable with no setup.
    task automatic run_xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                            input int mode, input int n, input logic rerr, input logic [DW-1:0] rd);
        int            exp_req, exp_edge;
        logic          exp_err;
        logic [DW-1:0] exp_rd;
        int            req_cnt = 0, rdy_cnt = 0, stray = 0, req_k = -1, k_p = -1;
        int            lim = TO + 12;
        logic [AW-1:0] got_addr = '0;
        logic          got_wr = 1'b0, got_err = 1'b0;
        logic [DW-1:0] got_wd = '0, got_rd = '0;
        bit            bus_on = 1'b1;

        // Reference outcome straight from the transfer rules.
        if (mode == 3 || (addr & AW'(DW/8 - 1)) != '0) begin
            exp_req = 0; exp_edge = 1; exp_err = 1'b1; exp_rd = '0;
        end else if (mode == 2) begin
            exp_req = 1; exp_edge = -1; exp_err = 1'b0; exp_rd = '0;
        end else if (mode == 1 || n > TO) begin
            exp_req = 1; exp_edge = 2 + TO; exp_err = 1'b1; exp_rd = '0;
        end else begin
            exp_req = 1; exp_edge = 2 + n; exp_err = rerr; exp_rd = wr ? '0 : rd;
        end

        paddr = addr; pwrite = wr; pwdata = wd; pselx = 1'b1; penable = (mode == 3); rsp_valid = 1'b0;
        for (int k = 0; k <= lim; k++) begin
            @(posedge clk); @(negedge clk);
            if (o_req_valid) begin
                req_cnt++;
                if (o_pready) stray++;
                if (req_k < 0) begin
                    req_k = k; got_addr = o_req_addr; got_wr = o_req_write; got_wd = o_req_wdata;
                end
            end
            if (o_pready) begin
                rdy_cnt++;
                if (k_p < 0) begin k_p = k; got_err = o_pslverr; got_rd = o_prdata; end
            end else if (o_prdata != '0 || o_pslverr) begin
                stray++;
            end
            if ((k_p >= 0 && k == k_p + 1 + (mode == 1 ? 3 : 0)) || (mode == 2 && k == n + 8) || k == lim)
                break;
            rsp_valid = 1'b0; rsp_rdata = $urandom; rsp_error = 1'($urandom);
            if (mode == 0 && req_k >= 0 && k == req_k + 1 + n) begin
                rsp_valid = 1'b1; rsp_rdata = rd; rsp_error = rerr;
            end
            if (mode == 2 && req_k >= 0 && k == req_k + 3 + n) rsp_valid = 1'b1;
            if (mode == 1 && k_p >= 0 && k == k_p + 1) rsp_valid = 1'b1;
            if (mode == 2 && k == 1 + n) bus_on = 1'b0;
            if (k_p >= 0 && k >= k_p + 1) bus_on = 1'b0;
            if (bus_on) begin
                pselx = 1'b1; penable = 1'b1;
                paddr = AW'($urandom); pwdata = $urandom; pwrite = 1'($urandom);
            end else begin
                pselx = 1'b0; penable = 1'b0;
            end
        end
        pselx = 1'b0; penable = 1'b0; rsp_valid = 1'b0;

        chk("req_count", req_cnt, exp_req);
        if (exp_req != 0) begin
            chk("req_addr", got_addr, addr);
            chk("req_write", got_wr, wr);
            chk("req_wdata", got_wd, wr ? wd : '0);
        end
        chk("pready_count", rdy_cnt, (exp_edge >= 0) ? 1 : 0);
        chk("pready_edge", k_p, exp_edge);
        if (exp_edge >= 0) begin
            chk("pslverr", got_err, exp_err);
            chk("prdata", got_rd, exp_rd);
        end
        chk("outside_completion", stray, 0);
    endtask

    initial begin
        int mode, n;
        logic [AW-1:0] a;

        repeat (3) @(negedge clk);
        chk("rst_pready", o_pready, 0);
        chk("rst_prdata", o_prdata, 0);
        chk("rst_pslverr", o_pslverr, 0);
        chk("rst_req_valid", o_req_valid, 0);
        chk("rst_req_fields", {o_req_write, o_req_addr, o_req_wdata}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_xfer(20'h00010, 1'b1, 32'hDEADBEEF, 0, 3, 1'b0, 32'h0);
        idle(2);
        run_xfer(20'h00020, 1'b0, 32'h0, 0, 2, 1'b0, 32'h12345678);
        run_xfer(20'h00020, 1'b0, 32'h0, 0, 1, 1'b1, 32'h12345678);
        idle(1);
        run_xfer(20'h00022, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0);
        run_xfer(20'h00030, 1'b0, 32'h0, 1, 0, 1'b0, 32'h0);
        run_xfer(20'h00034, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0BADF00D);
        run_xfer(20'h00038, 1'b0, 32'h0, 0, TO, 1'b0, 32'h55AA55AA);
        run_xfer(20'h0003C, 1'b1, 32'h01020304, 0, TO + 1, 1'b0, 32'h0);
        idle(1);
        run_xfer(20'h00040, 1'b0, 32'h0, 2, 1, 1'b0, 32'hFFFF0000);
        run_xfer(20'h00044, 1'b0, 32'h0, 0, 2, 1'b0, 32'h87654321);
        idle(1);
        run_xfer(20'h00048, 1'b0, 32'h0, 3, 0, 1'b0, 32'h0);

        // Asynchronous reset in WAIT with a response pending.
        idle(1);
        paddr = 20'h00050; pwrite = 1'b1; pwdata = 32'hCAFEF00D; pselx = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        repeat (2) @(negedge clk);
        rsp_valid = 1'b1; rsp_rdata = 32'h11111111;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pready_pslverr", {o_pready, o_pslverr, o_req_valid}, 0);
        chk("arst_prdata", o_prdata, 0);
        chk("arst_req_addr_write", {o_req_write, o_req_addr}, 0);
        chk("arst_req_wdata", o_req_wdata, 0);
        pselx = 1'b0; penable = 1'b0; rsp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_xfer(20'h00060, 1'b0, 32'h0, 0, 0, 1'b0, 32'hA1B2C3D4);
        run_xfer(20'h00064, 1'b1, 32'h99887766, 0, 1, 1'b0, 32'h0);

        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 7);
            mode = $urandom_range(0, 9);
            mode = (mode < 7) ? 0 : (mode == 7) ? 1 : (mode == 8) ? 2 : 3;
            a = AW'($urandom);
            if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            run_xfer(a, 1'($urandom), $urandom, mode, n, ($urandom_range(0, 3) == 0), $urandom);
            if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb3_completer_bridge.md
# apb3_completer_bridge

APB3 completer (slave) that terminates transfers from an APB3 requester and forwards each one as a single-beat request on a simple valid/response back-end port. It sits between the co-simulation APB3 bus and a register file or Renode-side peripheral model. It adds wait states until the back-end answers. It converts back-end errors, misaligned accesses, protocol violations and timeouts into `pslverr`.

## Interface
- `AddressWidth`, 20: width of `paddr` and `req_addr`.
- `DataWidth`, 32: width of data buses; legal values 8, 16, 32.
- `TimeoutCycles`, 16: maximum back-end wait, in cycles, before an error completion; must be ≥1.
- `clk` in 1: bus clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `paddr` in AddressWidth: APB address.
- `pselx` in 1: APB select.
- `penable` in 1: APB enable (access phase).
- `pwrite` in 1: 1 = write, 0 = read.
- `pwdata` in DataWidth: write data.
- `pready` out 1: transfer completes this cycle.
- `prdata` out DataWidth: read data, valid with `pready` on reads.
- `pslverr` out 1: error, valid with `pready`.
- `req_valid` out 1: one-cycle back-end request strobe.
- `req_write` out 1: latched `pwrite`.
- `req_addr` out AddressWidth: latched `paddr`.
- `req_wdata` out DataWidth: latched `pwdata`; 0 for reads.
- `rsp_valid` in 1: back-end response strobe.
- `rsp_rdata` in DataWidth: read data, sampled with `rsp_valid`.
- `rsp_error` in 1: back-end error, sampled with `rsp_valid`.

## Operation
- All outputs are registered. Reset value of every output is 0. The state machine resets to IDLE and the timeout counter resets to 0.
- The state machine has five states: IDLE, REQ, WAIT, RESP, ERR.
- **IDLE**
  - Setup is detected at an edge where `pselx=1` and `penable=0`.
  - On setup, latch `paddr`, `pwrite` and `pwdata` into the `req_*` registers.
  - If the address is aligned, go to REQ.
  - Misalignment means any of the low log2(DataWidth/8) address bits is nonzero. A misaligned setup goes to ERR and makes no back-end request.
  - An edge with `pselx=1`, `penable=1` and no preceding setup is a protocol violation: go to ERR.
- **REQ**
  - `req_valid=1` for exactly this one cycle.
  - Go to WAIT, with the counter cleared.
- **WAIT**
  - If `rsp_valid=1` at the edge, capture data: `prdata <= rsp_rdata` for reads, 0 for writes. Capture `pslverr <= rsp_error`. Go to RESP.
  - Otherwise increment the counter.
  - When the counter reaches TimeoutCycles, go to ERR.
- **RESP / ERR**
  - `pready=1` for exactly one cycle. ERR forces `pslverr=1` and `prdata=0`.
  - Then go to IDLE and clear `prdata`, `pslverr` and `pready`.
- **Abort:** if `pselx` falls in REQ or WAIT, return to IDLE and drop the transfer. `pready` is not asserted.
- **Stray and late responses:** `rsp_valid` outside WAIT is ignored. This includes a late response after a timeout or an abort.
- **Outputs outside a completion:** `prdata` is 0 except in the completion cycle of a read. `pslverr` is 0 except in the completion cycle.
- **Ignored bus changes:** changes on `paddr`, `pwrite` or `pwdata` after setup are ignored; the latched values are used.
- **Back-to-back transfers:** a new setup is accepted in the cycle right after completion, i.e. the cycle in which the state is IDLE.
- **Reset mid-transfer:** the state goes to IDLE immediately and all outputs go to 0. A response pending at reset is discarded.

## Timing
- Cycle reference: setup is sampled at edge E0 and REQ is active E0–E1.
- With a same-cycle back-end (`rsp_valid` high during REQ), `rsp_valid` is first sampled in WAIT at E2. RESP and `pready` are high E2–E3, and the transfer completes at E3. That is two wait states, the minimum.
- With a response N cycles after `req_valid`, `pready` rises at edge E(2+N).
- Timeout: with no response, `pready` with `pslverr=1` is high from E(2+TimeoutCycles) to E(3+TimeoutCycles).
- Misaligned access or protocol violation: `pready` is high E1–E2, so the completion has one wait state.
- `req_valid` is asserted at most once per transfer and never while `pready=1`.

## Test plan
- **Aligned write:** write to 0x00010 with data 0xDEADBEEF; back-end answers 3 cycles after `req_valid` with `rsp_error=0` → exactly one `req_valid` with `req_write=1`, `req_addr=0x00010`, `req_wdata=0xDEADBEEF`; `pready` rises at E5 with `pslverr=0` and `prdata=0`.
- **Aligned read:** read of 0x00020; back-end returns 0x12345678 with `rsp_error=0` → `prdata=0x12345678` during the single `pready` cycle, 0 before and after; `pslverr=0`. Repeat with `rsp_error=1` → `pslverr=1` and data as returned.
- **Misaligned:** read at 0x00022 → no `req_valid`; `pready=1` and `pslverr=1` at E1–E2; `prdata=0`.
- **Timeout:** TimeoutCycles=16 and the back-end never responds → `pslverr=1` at E18–E19. A late `rsp_valid` 2 cycles later causes no change on the outputs.
- **Abort:** drop `pselx` in WAIT → no `pready`, return to IDLE. A following aligned read then completes normally with its own data.
- **Async reset:** pulse `rst_n` low mid-WAIT (not clock-aligned) → all outputs are 0 immediately. Two back-to-back transfers after reset complete with correct data and no extra `req_valid`.
